// File: rtl/spi_master_multi_pkg.sv
// Shared definitions for the multi-mode SPI master: ctrl/status register layout,
// FSM state encoding and the decoded per-frame mode bits.
package spi_master_multi_pkg;

    localparam int CTRL_WIDTH_LSB = 0;
    localparam int CTRL_WIDTH_W   = 6;
    localparam int CTRL_DIV_LSB   = 8;
    localparam int CTRL_CPOL      = 16;
    localparam int CTRL_CPHA      = 17;
    localparam int CTRL_CS_LSB    = 18;
    localparam int CTRL_CS_W      = 3;
    localparam int CTRL_HOLD      = 21;
    localparam int CTRL_LSB_FIRST = 22;

    localparam int STAT_DONE = 0;
    localparam int STAT_BUSY = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LEAD,
        ST_TRAIL,
        ST_TAIL
    } state_t;

    typedef struct packed {
        logic                 cpol;
        logic                 cpha;
        logic [CTRL_CS_W-1:0] cs_sel;
        logic                 hold_cs;
        logic                 lsb_first;
    } mode_t;

    function automatic mode_t decode_mode(input logic [31:0] c);
        mode_t m;
        m.cpol      = c[CTRL_CPOL];
        m.cpha      = c[CTRL_CPHA];
        m.cs_sel    = c[CTRL_CS_LSB +: CTRL_CS_W];
        m.hold_cs   = c[CTRL_HOLD];
        m.lsb_first = c[CTRL_LSB_FIRST];
        return m;
    endfunction

endpackage

// File: rtl/spi_master_multi_if.sv
// CPU-side register bus of the SPI master: start strobe, control word, data in/out, status.
interface spi_master_multi_if #(
    parameter int MAX_WIDTH = 32
);
    logic                 start;
    logic [31:0]          ctrl_reg;
    logic [MAX_WIDTH-1:0] din;
    logic [MAX_WIDTH-1:0] dout;
    logic [31:0]          status_reg;

    modport master (output start, ctrl_reg, din, input dout, status_reg);
    modport slave  (input start, ctrl_reg, din, output dout, status_reg);
endinterface

// File: rtl/spi_clk_gen.sv
// Half-period tick generator: after load, emits a 1-cycle tick every div cycles while en.
module spi_clk_gen #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);
    logic [DIV_WIDTH-1:0] cnt;

    // div is already sanitised to >= 1 by the caller
    assign tick = en && !load && (cnt == div - DIV_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (reset || load) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + DIV_WIDTH'(1);
        end
    end
endmodule

// File: rtl/spi_master_multi.sv
// Memory-mapped SPI master with run-time CPOL/CPHA, bit order, frame width,
// chip select choice and CS hold across frames.
module spi_master_multi
    import spi_master_multi_pkg::*;
#(
    parameter int MAX_WIDTH = 32,
    parameter int NUM_CS    = 4,
    parameter int DIV_WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    spi_master_multi_if.slave bus,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_CS-1:0] cs_n
);
    localparam int CW = $clog2(MAX_WIDTH + 1);
    localparam int IW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

    state_t               state, state_nxt;
    mode_t                mode, mode_new;
    logic [CW-1:0]        w_lat, bit_cnt, w_san;
    logic [DIV_WIDTH-1:0] d_lat, d_san;
    logic [MAX_WIDTH-1:0] tx_lat, rx;
    logic [NUM_CS-1:0]    cs_sel_n;
    logic [CTRL_WIDTH_W-1:0] w_raw;
    logic [DIV_WIDTH-1:0] d_raw;
    logic                 busy, done, tick, last_bit, accept;
    logic                 unused_ctrl;

    assign unused_ctrl = ^{bus.ctrl_reg[31:23], bus.ctrl_reg[7:6]};

    always_comb begin
        w_raw    = bus.ctrl_reg[CTRL_WIDTH_LSB +: CTRL_WIDTH_W];
        d_raw    = bus.ctrl_reg[CTRL_DIV_LSB +: DIV_WIDTH];
        mode_new = decode_mode(bus.ctrl_reg);
        if (w_raw == '0)                  w_san = CW'(1);
        else if (int'(w_raw) > MAX_WIDTH) w_san = CW'(MAX_WIDTH);
        else                              w_san = CW'(w_raw);
        d_san = (d_raw == '0) ? DIV_WIDTH'(1) : d_raw;
    end

    // Active-low one-hot of the latched select; out-of-range selects nothing
    always_comb begin
        cs_sel_n = '1;
        for (int i = 0; i < NUM_CS; i++)
            if (int'(mode.cs_sel) == i) cs_sel_n[i] = 1'b0;
    end

    // Frame bit k maps to data bit k (LSB first) or W-1-k (MSB first)
    function automatic logic [IW-1:0] bit_idx(input logic [CW-1:0] k);
        logic [CW-1:0] r;
        r = mode.lsb_first ? k : (w_lat - CW'(1) - k);
        return IW'(r);
    endfunction

    assign accept   = (state == ST_IDLE) && bus.start;
    assign last_bit = (bit_cnt == w_lat - CW'(1));

    spi_clk_gen #(.DIV_WIDTH(DIV_WIDTH)) u_clk_gen (
        .clk   (clk),
        .reset (reset),
        .load  (state == ST_SETUP),
        .en    (state == ST_LEAD || state == ST_TRAIL || state == ST_TAIL),
        .div   (d_lat),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.start) state_nxt = ST_SETUP;
            ST_SETUP: state_nxt = ST_LEAD;
            ST_LEAD:  if (tick) state_nxt = ST_TRAIL;
            ST_TRAIL: if (tick) state_nxt = last_bit ? ST_TAIL : ST_LEAD;
            ST_TAIL:  if (tick) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode    <= '0;
            w_lat   <= CW'(1);
            d_lat   <= DIV_WIDTH'(1);
            tx_lat  <= '0;
            rx      <= '0;
            bit_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            cs_n    <= '1;
        end else begin
            case (state)
                ST_IDLE: begin
                    sclk <= bus.ctrl_reg[CTRL_CPOL];
                    if (accept) begin
                        mode   <= mode_new;
                        w_lat  <= w_san;
                        d_lat  <= d_san;
                        tx_lat <= bus.din;
                        // a held CS that is not reselected drops out one cycle early
                        if (mode_new.cs_sel != mode.cs_sel) cs_n <= '1;
                    end
                end
                ST_SETUP: begin
                    busy    <= 1'b1;
                    done    <= 1'b0;
                    rx      <= '0;
                    bit_cnt <= '0;
                    cs_n    <= cs_sel_n;
                    if (!mode.cpha) mosi <= tx_lat[bit_idx('0)];
                end
                ST_LEAD: if (tick) begin
                    sclk <= ~mode.cpol;
                    if (mode.cpha) mosi <= tx_lat[bit_idx(bit_cnt)];
                    else           rx[bit_idx(bit_cnt)] <= miso;
                end
                ST_TRAIL: if (tick) begin
                    sclk <= mode.cpol;
                    if (mode.cpha)      rx[bit_idx(bit_cnt)] <= miso;
                    else if (!last_bit) mosi <= tx_lat[bit_idx(bit_cnt + CW'(1))];
                    if (!last_bit) bit_cnt <= bit_cnt + CW'(1);
                end
                ST_TAIL: if (tick) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (!mode.hold_cs) cs_n <= '1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.status_reg            = '0;
        bus.status_reg[STAT_DONE] = done;
        bus.status_reg[STAT_BUSY] = busy;
    end

    assign bus.dout = rx;
endmodule
